// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART command parser slice.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_ARG  = 2'd2,
        S_SUM  = 2'd3
    } state_t;

    localparam logic [7:0] HDR_DEFAULT    = 8'hAA;

    localparam logic [7:0] CMD_PLAY_PAUSE = 8'h01;
    localparam logic [7:0] CMD_NEXT       = 8'h02;
    localparam logic [7:0] CMD_PREV       = 8'h03;
    localparam logic [7:0] CMD_VOL_SET    = 8'h10;
    localparam logic [7:0] CMD_VOL_UP     = 8'h11;
    localparam logic [7:0] CMD_VOL_DOWN   = 8'h12;

    function automatic logic cmd_known(input logic [7:0] code);
        case (code)
            CMD_PLAY_PAUSE, CMD_NEXT, CMD_PREV,
            CMD_VOL_SET, CMD_VOL_UP, CMD_VOL_DOWN: cmd_known = 1'b1;
            default:                               cmd_known = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser_if
//  Purpose  : Received-byte stream in, decoded player controls out.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic       playing;
    logic       next_pulse;
    logic       prev_pulse;
    logic [7:0] volume;

    modport master (
        output rx_data, rx_valid,
        input  cmd_valid, cmd_code, cmd_arg, frame_err,
               playing, next_pulse, prev_pulse, volume
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd_valid, cmd_code, cmd_arg, frame_err,
               playing, next_pulse, prev_pulse, volume
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser_exec.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_exec
//  Purpose  : Registered action unit; owns play state, volume and pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_exec
    import uart_pkg::*;
#(
    parameter logic [7:0] VOL_MAX  = 8'd31,
    parameter logic [7:0] VOL_INIT = 8'd16
) (
    input  wire logic       uart_clk,
    input  wire logic       rst_n,
    input  wire logic       i_frame_ok,
    input  wire logic [7:0] i_code,
    input  wire logic [7:0] i_arg,
    output logic            o_cmd_valid,
    output logic [7:0]      o_cmd_code,
    output logic [7:0]      o_cmd_arg,
    output logic            o_playing,
    output logic            o_next_pulse,
    output logic            o_prev_pulse,
    output logic [7:0]      o_volume
);

    logic       cmd_valid_q,  cmd_valid_d;
    logic [7:0] cmd_code_q,   cmd_code_d;
    logic [7:0] cmd_arg_q,    cmd_arg_d;
    logic       playing_q,    playing_d;
    logic       next_pulse_q, next_pulse_d;
    logic       prev_pulse_q, prev_pulse_d;
    logic [7:0] volume_q,     volume_d;

    // 9-bit views so the saturation compares cannot wrap
    logic [8:0] w_vol_max9;
    logic [8:0] w_vol_inc9;
    logic [8:0] w_arg9;

    assign w_vol_max9 = {1'b0, VOL_MAX};
    assign w_vol_inc9 = {1'b0, volume_q} + 9'd1;
    assign w_arg9     = {1'b0, i_arg};

    always_comb begin
        cmd_valid_d  = 1'b0;
        next_pulse_d = 1'b0;
        prev_pulse_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        cmd_arg_d    = cmd_arg_q;
        playing_d    = playing_q;
        volume_d     = volume_q;

        if (i_frame_ok) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = i_code;
            cmd_arg_d   = i_arg;
            case (i_code)
                CMD_PLAY_PAUSE: playing_d    = ~playing_q;
                CMD_NEXT:       next_pulse_d = 1'b1;
                CMD_PREV:       prev_pulse_d = 1'b1;
                CMD_VOL_SET:    volume_d = (w_arg9 > w_vol_max9) ? VOL_MAX : i_arg;
                CMD_VOL_UP:     volume_d = (w_vol_inc9 > w_vol_max9) ? VOL_MAX : w_vol_inc9[7:0];
                CMD_VOL_DOWN:   volume_d = (volume_q == 8'd0) ? 8'd0 : volume_q - 8'd1;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= 8'd0;
            cmd_arg_q    <= 8'd0;
            playing_q    <= 1'b0;
            next_pulse_q <= 1'b0;
            prev_pulse_q <= 1'b0;
            volume_q     <= VOL_INIT;
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_arg_q    <= cmd_arg_d;
            playing_q    <= playing_d;
            next_pulse_q <= next_pulse_d;
            prev_pulse_q <= prev_pulse_d;
            volume_q     <= volume_d;
        end
    end

    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_code   = cmd_code_q;
    assign o_cmd_arg    = cmd_arg_q;
    assign o_playing    = playing_q;
    assign o_next_pulse = next_pulse_q;
    assign o_prev_pulse = prev_pulse_q;
    assign o_volume     = volume_q;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_parser
//  Purpose  : Assembles HDR/CMD/ARG/SUM frames from UART bytes and validates them.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  HDR      = HDR_DEFAULT,
    parameter logic [7:0]  VOL_MAX  = 8'd31,
    parameter logic [7:0]  VOL_INIT = 8'd16,
    parameter int unsigned TIMEOUT  = 312500
) (
    input wire logic         uart_clk,
    input wire logic         rst_n,
    uart_cmd_parser_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       cmd_q,   cmd_d;
    logic [7:0]       arg_q,   arg_d;
    logic             frame_err_q, frame_err_d;
    logic             w_frame_ok;
    logic [7:0]       w_sum;

    assign w_sum = cmd_q + arg_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        frame_err_d = 1'b0;
        w_frame_ok  = 1'b0;

        if (bus.rx_valid) begin
            // a byte arriving on the deadline cycle beats the timeout
            cnt_d = '0;
            case (state_q)
                S_IDLE: if (bus.rx_data == HDR) state_d = S_CMD;
                S_CMD: begin
                    cmd_d   = bus.rx_data;
                    state_d = S_ARG;
                end
                S_ARG: begin
                    arg_d   = bus.rx_data;
                    state_d = S_SUM;
                end
                S_SUM: begin
                    state_d = S_IDLE;
                    if ((w_sum == bus.rx_data) && cmd_known(cmd_q)) w_frame_ok  = 1'b1;
                    else                                            frame_err_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                frame_err_d = 1'b1;
                state_d     = S_IDLE;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_q       <= 8'd0;
            arg_q       <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;

    uart_cmd_exec #(
        .VOL_MAX  (VOL_MAX),
        .VOL_INIT (VOL_INIT)
    ) u_exec (
        .uart_clk     (uart_clk),
        .rst_n        (rst_n),
        .i_frame_ok   (w_frame_ok),
        .i_code       (cmd_q),
        .i_arg        (arg_q),
        .o_cmd_valid  (bus.cmd_valid),
        .o_cmd_code   (bus.cmd_code),
        .o_cmd_arg    (bus.cmd_arg),
        .o_playing    (bus.playing),
        .o_next_pulse (bus.next_pulse),
        .o_prev_pulse (bus.prev_pulse),
        .o_volume     (bus.volume)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_parser
//  Purpose  : Scoreboard bench for uart_cmd_parser frame decode and timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int unsigned TB_TIMEOUT = 20;

    typedef struct packed {
        logic       cv;
        logic       fe;
        logic       np;
        logic       pp;
        logic [7:0] code;
        logic [7:0] arg;
        logic       play;
        logic [7:0] vol;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    evt_t exp_q[$];

    logic       m_play;
    logic [7:0] m_vol, m_code, m_arg;

    uart_cmd_parser_if u_if ();

    uart_cmd_parser #(.TIMEOUT(TB_TIMEOUT)) dut (
        .uart_clk (clk),
        .rst_n    (rst_n),
        .bus      (u_if.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (u_if.cmd_valid || u_if.frame_err || u_if.next_pulse || u_if.prev_pulse)) begin
            evt_t act, e;
            act = '{u_if.cmd_valid, u_if.frame_err, u_if.next_pulse, u_if.prev_pulse,
                    u_if.cmd_code, u_if.cmd_arg, u_if.playing, u_if.volume};
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event got=%h expected=none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL event got cv%b fe%b np%b pp%b code=%h arg=%h play=%b vol=%0d expected cv%b fe%b np%b pp%b code=%h arg=%h play=%b vol=%0d",
                             act.cv, act.fe, act.np, act.pp, act.code, act.arg, act.play, act.vol,
                             e.cv, e.fe, e.np, e.pp, e.code, e.arg, e.play, e.vol);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_play = 1'b0;
        m_vol  = 8'd16;
        m_code = 8'd0;
        m_arg  = 8'd0;
    endtask

    task automatic push_err();
        exp_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, m_code, m_arg, m_play, m_vol});
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic send_byte(input logic [7:0] b);
        u_if.rx_valid = 1'b1;
        u_if.rx_data  = b;
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s);
        logic np, pp;
        np = 1'b0;
        pp = 1'b0;
        if (s != 8'(c + a)) begin
            push_err();
        end else begin
            case (c)
                8'h01: m_play = ~m_play;
                8'h02: np = 1'b1;
                8'h03: pp = 1'b1;
                8'h10: m_vol = (a > 8'd31) ? 8'd31 : a;
                8'h11: m_vol = (m_vol >= 8'd31) ? 8'd31 : m_vol + 8'd1;
                8'h12: m_vol = (m_vol == 8'd0) ? 8'd0 : m_vol - 8'd1;
                default: ;
            endcase
            if (c inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12}) begin
                m_code = c;
                m_arg  = a;
                exp_q.push_back('{1'b1, 1'b0, np, pp, m_code, m_arg, m_play, m_vol});
            end else begin
                push_err();
            end
        end
        send_byte(8'hAA);
        send_byte(c);
        send_byte(a);
        send_byte(s);
    endtask

    initial begin
        int waited;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        model_reset();
        idle(3);
        rst_n = 1'b1;

        check("reset_cmd_code", u_if.cmd_code, 8'h00);
        check("reset_cmd_arg",  u_if.cmd_arg,  8'h00);
        check("reset_volume",   u_if.volume,   8'd16);
        check("reset_flags", {4'd0, u_if.playing, u_if.cmd_valid, u_if.next_pulse, u_if.prev_pulse}, 8'h00);
        check("reset_err",      {7'd0, u_if.frame_err}, 8'h00);

        send_frame(8'h01, 8'h00, 8'h01);
        send_frame(8'h01, 8'h00, 8'h01);

        send_frame(8'h10, 8'h40, 8'h50);
        for (int i = 0; i < 32; i++) send_frame(8'h12, 8'h00, 8'h12);
        send_frame(8'h11, 8'h00, 8'h11);

        send_frame(8'h02, 8'h00, 8'h03);
        send_frame(8'h02, 8'h00, 8'h02);

        push_err();
        send_byte(8'hAA);
        send_byte(8'h03);
        idle(TB_TIMEOUT + 5);
        send_frame(8'h03, 8'h00, 8'h03);

        send_byte(8'h55);
        send_frame(8'h7F, 8'h01, 8'h80);
        send_frame(8'h10, 8'h05, 8'h15);

        idle(3);
        send_byte(8'hAA);
        send_byte(8'h10);
        rst_n = 1'b0;
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(2);
        check("midreset_volume",  u_if.volume, 8'd16);
        check("midreset_playing", {7'd0, u_if.playing}, 8'h00);
        check("midreset_code",    u_if.cmd_code, 8'h00);
        send_frame(8'h01, 8'h00, 8'h01);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(2);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        check("final_playing", {7'd0, u_if.playing}, 8'h01);
        check("final_volume",  u_if.volume, 8'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
